vga_sync_decoder: RTL

Receive-side counterpart of the VGA timing generator. It watches an incoming active-low hsync/vsync pair and rebuilds the pixel coordinates and display-enable from them. It also measures line length and frame height, declares lock, and flags timing errors. It sits on the capture/loopback path, where it checks the generator's sync output and re-derives `xCount`/`yCount`-style coordinates for downstream overlay logic.

---
 rtl/vga_sync_decoder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Sync-side timing recovery: rebuilds pixel coordinates and display enable from
// an active-low hsync/vsync pair, measures line/frame timing and tracks lock.
module vga_sync_decoder #(
  parameter int H_TOTAL    = 794,
  parameter int H_ACTIVE   = 640,
  parameter int H_BACK     = 139,
  parameter int V_TOTAL    = 526,
  parameter int V_ACTIVE   = 480,
  parameter int V_BACK     = 36,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        de,
  output logic        locked,
  output logic        hs_err,
  output logic        vs_err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines
);

  // state   | meaning
  // SEARCH  | no reference; first hsync fall starts line measurement
  // ACQUIRE | counting consecutive good lines after a vsync fall
  // LOCKED  | timing trusted; de/x/y valid, any bad timing drops lock
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam int GW = $clog2(LOCK_LINES + 1);

  localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
  localparam logic [10:0] H_LAST_C   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BEG_C    = 11'(H_BACK);
  localparam logic [10:0] H_END_C    = 11'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
  localparam logic [9:0]  V_BEG_C    = 10'(V_BACK);
  localparam logic [9:0]  V_END_C    = 10'(V_BACK + V_ACTIVE);
  localparam logic [GW-1:0] LOCK_C   = GW'(LOCK_LINES);

  logic hs_q, hs_d, vs_q, vs_d;
  logic h_edge, v_edge;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;

  state_t state, state_nx;
  logic [GW-1:0] good_cnt, good_cnt_nx;
  logic v_seen, v_seen_nx;

  logic        line_good, frame_good;
  logic        line_chk, frame_chk;
  logic        hs_missing, line_bad_lk, frame_bad_lk, lose_lock;
  logic [10:0] line_meas;
  logic [9:0]  frame_meas;
  logic        in_h, in_v;

  logic        de_nx, locked_nx, hs_err_nx, vs_err_nx;
  logic [9:0]  x_nx, y_nx, frame_lines_nx;
  logic [10:0] line_len_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      hs_d <= 1'b1;
      vs_q <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_q <= vga_hsync;
      hs_d <= hs_q;
      vs_q <= vga_vsync;
      vs_d <= vs_q;
    end
  end

  assign h_edge = hs_d & ~hs_q;
  assign v_edge = vs_d & ~vs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (h_edge)
        hcnt <= '0;
      else if (hcnt != 11'h7ff)
        hcnt <= hcnt + 11'd1;

      if (v_edge)
        vcnt <= '0;
      else if (h_edge && vcnt != 10'h3ff)
        vcnt <= vcnt + 10'd1;
    end
  end

  // a vsync fall that coincides with an hsync fall closes the line in progress too
  always_comb begin
    line_meas  = (hcnt == 11'h7ff) ? hcnt : hcnt + 11'd1;
    frame_meas = (h_edge && vcnt != 10'h3ff) ? vcnt + 10'd1 : vcnt;
    line_good  = (hcnt == H_LAST_C);
    frame_good = (frame_meas == V_TOTAL_C);
    line_chk   = h_edge && (state != SEARCH);
    frame_chk  = v_edge && v_seen;
    hs_missing   = (state == LOCKED) && !h_edge && (hcnt == H_LAST_C);
    line_bad_lk  = (state == LOCKED) && line_chk && !line_good;
    frame_bad_lk = (state == LOCKED) && frame_chk && !frame_good;
    lose_lock    = line_bad_lk || frame_bad_lk || hs_missing;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      v_seen   <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_cnt_nx;
      v_seen   <= v_seen_nx;
    end
  end

  // good lines only count once the frame phase is known, so lock always
  // follows a vsync fall plus LOCK_LINES good lines
  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    v_seen_nx   = v_seen | v_edge;
    case (state)
      SEARCH: begin
        if (h_edge) begin
          state_nx    = ACQUIRE;
          good_cnt_nx = '0;
        end
      end
      ACQUIRE: begin
        if (line_chk) begin
          if (!line_good)
            good_cnt_nx = '0;
          else if (v_seen && good_cnt != LOCK_C)
            good_cnt_nx = good_cnt + 1'b1;
        end
        if (frame_chk && !frame_good)
          good_cnt_nx = '0;
        if (good_cnt_nx >= LOCK_C && v_seen_nx)
          state_nx = LOCKED;
      end
      LOCKED: begin
        if (lose_lock) begin
          state_nx  = SEARCH;
          v_seen_nx = 1'b0;
        end
      end
      default: begin
        state_nx  = SEARCH;
        v_seen_nx = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_h      = (hcnt >= H_BEG_C) && (hcnt < H_END_C);
    in_v      = (vcnt >= V_BEG_C) && (vcnt < V_END_C);
    de_nx     = (state == LOCKED) && in_h && in_v;
    x_nx      = de_nx ? 10'(hcnt - H_BEG_C) : 10'd0;
    y_nx      = de_nx ? (vcnt - V_BEG_C) : 10'd0;
    locked_nx = (state == LOCKED);
    hs_err_nx = line_bad_lk || hs_missing;
    vs_err_nx = frame_bad_lk;
    if (h_edge)
      line_len_nx = line_meas;
    else if (hs_missing)
      line_len_nx = H_TOTAL_C;
    else
      line_len_nx = line_len;
    frame_lines_nx = v_edge ? frame_meas : frame_lines;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_pos       <= '0;
      y_pos       <= '0;
      de          <= 1'b0;
      locked      <= 1'b0;
      hs_err      <= 1'b0;
      vs_err      <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      x_pos       <= x_nx;
      y_pos       <= y_nx;
      de          <= de_nx;
      locked      <= locked_nx;
      hs_err      <= hs_err_nx;
      vs_err      <= vs_err_nx;
      line_len    <= line_len_nx;
      frame_lines <= frame_lines_nx;
    end
  end

endmodule
